// File: rtl/chacha_host.sv
// Host-side sequencer for the byte-serial chacha keystream core: loads key/nonce/counter,
// fetches 64-byte keystream blocks and XORs them onto a valid/ready payload stream.
module chacha_host #(
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [7:0] cfg_data,
   input  logic       abort,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       ctr_wrap,
   output logic       core_wr_key,
   output logic       core_wr_nnc,
   output logic       core_wr_ctr,
   output logic       core_hold,
   input  logic       core_blk_ready,
   output logic       core_rd_blk,
   output logic [7:0] core_din,
   input  logic [7:0] core_dout
);
   // state    | meaning
   // S_IDLE   | collecting the 48 config bytes
   // S_WR_KEY | bursting key bytes 0-31 into the core
   // S_WR_NNC | bursting nonce bytes 32-39
   // S_WR_CTR | bursting block counter bytes 40-47
   // S_WAIT   | core released, waiting for blk_ready
   // S_READ   | reading 64 keystream bytes into the local buffer
   // S_STREAM | XORing buffered keystream onto the payload
   typedef enum logic [2:0] {
      S_IDLE, S_WR_KEY, S_WR_NNC, S_WR_CTR, S_WAIT, S_READ, S_STREAM
   } state_t;

   localparam logic [7:0] LAT       = 8'(RD_LAT);
   localparam logic [7:0] READ_LAST = 8'(63 + RD_LAT);

   state_t       state;
   logic [383:0] cfg;
   logic [5:0]   bidx;
   logic [5:0]   bidx_nxt;
   logic [7:0]   cfg_nxt_byte;
   logic [63:0]  ctr_nxt;
   logic [7:0]   rcnt;
   logic [5:0]   cap_idx;
   logic [6:0]   rd_ptr;
   logic [7:0]   kbuf [64];
   logic         stream_ok;

   assign bidx_nxt     = bidx + 6'd1;
   assign cfg_nxt_byte = cfg[{bidx_nxt, 3'b000} +: 8];
   assign ctr_nxt      = cfg[383:320] + 64'd1;
   assign cap_idx      = 6'(rcnt - LAT);

   assign stream_ok = (state == S_STREAM) && !rd_ptr[6];
   assign in_ready  = stream_ok & out_ready;
   assign out_valid = stream_ok & in_valid;
   assign out_data  = in_data ^ kbuf[rd_ptr[5:0]];

   // The byte for read slot i shows up RD_LAT cycles later, so capture lags the slot count.
   always_ff @(posedge clk) begin
      if (rst_n && !abort && state == S_READ && rcnt >= LAT)
         kbuf[cap_idx] <= core_dout;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state       <= S_IDLE;
         bidx        <= '0;
         rcnt        <= '0;
         rd_ptr      <= '0;
         cfg_ready   <= 1'b1;
         core_hold   <= 1'b1;
         core_wr_key <= 1'b0;
         core_wr_nnc <= 1'b0;
         core_wr_ctr <= 1'b0;
         core_rd_blk <= 1'b0;
         core_din    <= '0;
         if (!rst_n)
            ctr_wrap <= 1'b0;
      end else begin
         core_wr_key <= 1'b0;
         core_wr_nnc <= 1'b0;
         core_wr_ctr <= 1'b0;
         core_rd_blk <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_valid && cfg_ready) begin
                  cfg[{bidx, 3'b000} +: 8] <= cfg_data;
                  if (bidx == 6'd47) begin
                     state       <= S_WR_KEY;
                     cfg_ready   <= 1'b0;
                     core_wr_key <= 1'b1;
                     core_din    <= cfg[7:0];
                     bidx        <= '0;
                  end else begin
                     bidx <= bidx_nxt;
                  end
               end
            end
            S_WR_KEY, S_WR_NNC: begin
               bidx     <= bidx_nxt;
               core_din <= cfg_nxt_byte;
               if (state == S_WR_KEY && bidx == 6'd31) begin
                  state       <= S_WR_NNC;
                  core_wr_nnc <= 1'b1;
               end else if (state == S_WR_NNC && bidx == 6'd39) begin
                  state       <= S_WR_CTR;
                  core_wr_ctr <= 1'b1;
               end
            end
            S_WR_CTR: begin
               if (bidx == 6'd47) begin
                  state     <= S_WAIT;
                  core_hold <= 1'b0;
               end else begin
                  bidx     <= bidx_nxt;
                  core_din <= cfg_nxt_byte;
               end
            end
            S_WAIT: begin
               if (core_blk_ready) begin
                  state       <= S_READ;
                  core_hold   <= 1'b1;
                  core_rd_blk <= 1'b1;
                  rcnt        <= '0;
               end
            end
            S_READ: begin
               rcnt <= rcnt + 8'd1;
               if (rcnt == READ_LAST) begin
                  state  <= S_STREAM;
                  rd_ptr <= '0;
               end
            end
            S_STREAM: begin
               if (rd_ptr[6]) begin
                  // Block used up: bump the counter and rewrite only the counter field.
                  cfg[383:320] <= ctr_nxt;
                  if (&cfg[383:320])
                     ctr_wrap <= 1'b1;
                  state       <= S_WR_CTR;
                  core_wr_ctr <= 1'b1;
                  core_din    <= ctr_nxt[7:0];
                  bidx        <= 6'd40;
               end else if (in_valid && out_ready) begin
                  rd_ptr <= rd_ptr + 7'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
